imem_loader: RTL and testbench

Byte-stream writer for the 1024 x 32 instruction memory. It takes a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. Each word goes out on a single-port write interface at consecutive word addresses. A trailing checksum byte closes the load. The block sits between the host/UART byte source and the instruction memory write port, and holds the pipeline CPU stalled while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int MEM_DEPTH   = 1 << IMEM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK
  } state_t;

  // Running checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them to consecutive
// instruction-memory addresses and closes the load with a checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   words_left;
  logic [1:0]        byte_cnt;
  logic [DATA_W-9:0] shift_reg;
  logic [7:0]        csum;
  logic              fire;

  // byte_ready is a registered copy of "state is LOAD or CHECK".
  assign fire = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
      csum       <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      // CPU is released one cycle after the done pulse; a new start below overrides.
      if (done) cpu_hold <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cur_addr   <= load_base;
            words_left <= word_count;
            byte_cnt   <= '0;
            csum       <= '0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
            if (word_count == '0) begin
              done <= 1'b1;
            end else if (word_count > DEPTH) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              state      <= LOAD;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (fire) begin
            csum <= csum_add(csum, byte_data);
            if (byte_cnt == 2'd3) begin
              wr_en      <= 1'b1;
              wr_addr    <= cur_addr;
              wr_data    <= {shift_reg, byte_data};
              cur_addr   <= cur_addr + ADDR_W'(1);
              words_left <= words_left - (ADDR_W+1)'(1);
              byte_cnt   <= '0;
              if (words_left == (ADDR_W+1)'(1)) state <= CHECK;
            end else begin
              shift_reg <= {shift_reg[DATA_W-17:0], byte_data};
              byte_cnt  <= byte_cnt + 2'd1;
            end
          end
        end

        CHECK: begin
          if (fire) begin
            state      <= IDLE;
            busy       <= 1'b0;
            byte_ready <= 1'b0;
            done       <= 1'b1;
            err        <= (byte_data != csum);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: checks write words/addresses, checksum
// handling, count boundaries, reset abort and ignored start.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = IMEM_ADDR_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW:0]   word_count = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, wr_en, cpu_hold, busy, done, err;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_base(load_base),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  int            done_cnt = 0;
  logic          done_err = 1'b0;
  logic          busy_seen = 1'b0;

  // Passive capture of every write and done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (done) begin
      done_cnt++;
      done_err = err;
    end
    if (busy) busy_seen = 1'b1;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [AW:0] cnt);
    @(negedge clk);
    start = 1'b1; load_base = base; word_count = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte and returns on the posedge where it is accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    byte_valid = 1'b1; byte_data = b;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_vec("byte_ready_timeout", byte_ready, 1);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run_bytes(input logic [7:0] bq[$], input int max_gap);
    int g;
    foreach (bq[k]) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      if (g > 0) begin
        drop_valid();
        repeat (g - 1) @(negedge clk);
      end
      send_byte(bq[k]);
    end
    drop_valid();
  endtask

  function automatic logic [7:0] sum8(input logic [7:0] bq[$]);
    logic [7:0] s = '0;
    foreach (bq[k]) s = s + bq[k];
    return s;
  endfunction

  function automatic logic [7:0] big_byte(input int k);
    return 8'(k ^ (k >> 8));
  endfunction

  logic [7:0] hp[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    logic [7:0] wsum;
    int d0, bad_a, bad_d, g, idx;
    logic [31:0] exp_w;

    // Reset values
    repeat (2) @(negedge clk);
    check_vec("rst_flags", {byte_ready, wr_en, cpu_hold, busy, done, err}, 0);
    check_vec("rst_wr_addr", wr_addr, 0);
    check_vec("rst_wr_data", wr_data, 0);
    rst_n = 1'b1;

    // Happy path, one byte per clock; 12+34+...+F0 mod 256 = 0x38
    wa_q.delete(); wd_q.delete(); d0 = done_cnt;
    do_start(0, 2);
    check_vec("hp_busy_after_start", busy, 1);
    check_vec("hp_hold_after_start", cpu_hold, 1);
    check_vec("hp_ready_after_start", byte_ready, 1);
    for (int k = 0; k < 8; k++) begin
      send_byte(hp[k]);
      #1;
      check_vec($sformatf("hp_wr_en_b%0d", k), wr_en, (k % 4 == 3));
      if (k == 3) begin
        check_vec("hp_w0_addr", wr_addr, 0);
        check_vec("hp_w0_data", wr_data, 32'h12345678);
        check_vec("hp_ready_in_wr", byte_ready, 1);
      end
      if (k == 7) begin
        check_vec("hp_w1_addr", wr_addr, 1);
        check_vec("hp_w1_data", wr_data, 32'h9ABCDEF0);
        check_vec("hp_ready_in_check", byte_ready, 1);
      end
    end
    send_byte(8'h38);
    drop_valid();
    check_vec("hp_done", done, 1);
    check_vec("hp_err", err, 0);
    check_vec("hp_busy_fall", busy, 0);
    check_vec("hp_hold_still", cpu_hold, 1);
    check_vec("hp_ready_fall", byte_ready, 0);
    @(negedge clk);
    check_vec("hp_hold_fall", cpu_hold, 0);
    check_vec("hp_done_pulse", done, 0);
    check_vec("hp_wdata_holds", wr_data, 32'h9ABCDEF0);
    check_vec("hp_write_count", wa_q.size(), 2);
    check_vec("hp_done_count", done_cnt - d0, 1);

    // Wrap-around with random gaps; an ignored start is pulsed mid-load
    wa_q.delete(); wd_q.delete(); d0 = done_cnt;
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
    wsum = sum8(bq);
    do_start(AW'(1023), 2);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        drop_valid();
        do_start(5, 7);
      end
      g = int'($urandom_range(0, 3));
      if (g > 0) begin
        drop_valid();
        repeat (g - 1) @(negedge clk);
      end
      send_byte(bq[k]);
    end
    send_byte(wsum);
    drop_valid();
    repeat (2) @(negedge clk);
    check_vec("wrap_write_count", wa_q.size(), 2);
    check_vec("wrap_addr0", wa_q[0], 1023);
    check_vec("wrap_data0", wd_q[0], 32'hA1B2C3D4);
    check_vec("wrap_addr1", wa_q[1], 0);
    check_vec("wrap_data1", wd_q[1], 32'h11223344);
    check_vec("wrap_done_count", done_cnt - d0, 1);
    check_vec("wrap_err", done_err, 0);

    // Bad checksum: sum is 0x01, 0x02 is sent
    wa_q.delete(); wd_q.delete(); d0 = done_cnt;
    do_start(AW'(16), 1);
    run_bytes('{8'h00, 8'h00, 8'h00, 8'h01, 8'h02}, 0);
    check_vec("bad_done", done, 1);
    check_vec("bad_err", err, 1);
    repeat (4) @(negedge clk);
    check_vec("bad_err_sticky", err, 1);
    check_vec("bad_write_count", wa_q.size(), 1);
    check_vec("bad_addr", wa_q[0], 16);
    check_vec("bad_data", wd_q[0], 32'h00000001);

    // word_count = 0: next start clears err, done next cycle, no writes, never busy
    wa_q.delete(); busy_seen = 1'b0;
    do_start(7, 0);
    check_vec("c0_done", done, 1);
    check_vec("c0_err_cleared", err, 0);
    check_vec("c0_hold", cpu_hold, 1);
    repeat (3) @(negedge clk);
    check_vec("c0_busy_seen", busy_seen, 0);
    check_vec("c0_write_count", wa_q.size(), 0);
    check_vec("c0_hold_fall", cpu_hold, 0);

    // word_count = 1025: rejected
    do_start(0, 11'd1025);
    check_vec("c1025_done", done, 1);
    check_vec("c1025_err", err, 1);
    repeat (3) @(negedge clk);
    check_vec("c1025_busy_seen", busy_seen, 0);
    check_vec("c1025_write_count", wa_q.size(), 0);

    // word_count = 1024: whole memory
    wa_q.delete(); wd_q.delete(); d0 = done_cnt;
    bq.delete();
    for (int k = 0; k < 4 * MEM_DEPTH; k++) bq.push_back(big_byte(k));
    wsum = sum8(bq);
    bq.push_back(wsum);
    do_start(0, 11'd1024);
    run_bytes(bq, 0);
    repeat (2) @(negedge clk);
    check_vec("c1024_write_count", wa_q.size(), MEM_DEPTH);
    bad_a = 0; bad_d = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      exp_w = {big_byte(4*i), big_byte(4*i+1), big_byte(4*i+2), big_byte(4*i+3)};
      if (wa_q[i] !== AW'(i)) bad_a++;
      if (wd_q[i] !== exp_w) bad_d++;
    end
    check_vec("c1024_addr_seq_bad", bad_a, 0);
    check_vec("c1024_data_seq_bad", bad_d, 0);
    idx = MEM_DEPTH - 1;
    exp_w = {big_byte(4*idx), big_byte(4*idx+1), big_byte(4*idx+2), big_byte(4*idx+3)};
    check_vec("c1024_last_data", wd_q[idx], exp_w);
    check_vec("c1024_done_count", done_cnt - d0, 1);
    check_vec("c1024_err", done_err, 0);

    // Reset after 2 bytes of the third word
    wa_q.delete(); wd_q.delete();
    do_start(0, 5);
    for (int k = 0; k < 10; k++) send_byte(8'(8'h40 + k));
    @(negedge clk);
    byte_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_vec("rstmid_flags", {byte_ready, wr_en, cpu_hold, busy, done, err}, 0);
    check_vec("rstmid_wr_addr", wr_addr, 0);
    check_vec("rstmid_wr_data", wr_data, 0);
    repeat (3) @(negedge clk);
    check_vec("rstmid_write_count", wa_q.size(), 2);
    rst_n = 1'b1;

    // Fresh load after the abort: CA+FE+BA+BE mod 256 = 0x40
    wa_q.delete(); wd_q.delete(); d0 = done_cnt;
    do_start(0, 1);
    run_bytes('{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h40}, 2);
    repeat (2) @(negedge clk);
    check_vec("post_rst_write_count", wa_q.size(), 1);
    check_vec("post_rst_addr", wa_q[0], 0);
    check_vec("post_rst_data", wd_q[0], 32'hCAFEBABE);
    check_vec("post_rst_done_count", done_cnt - d0, 1);
    check_vec("post_rst_err", done_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
